// File: rtl/sc_eval_sequencer_pkg.sv
// Shared types and constants for the stochastic-computing evaluation sequencer.
package sc_pkg;
   localparam int SC_PROB_W = 4;
   localparam int SC_LEN_W  = 8;
   localparam int SC_DP_LAT = 2;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      FLUSH,
      DONE
   } sc_state_e;
endpackage

// File: rtl/sc_eval_sequencer_if.sv
// Job, result and datapath-control bundle between host, sequencer and SC datapath.
interface sc_eval_sequencer_if
   import sc_pkg::*;
#(
   parameter int LEN_W = SC_LEN_W
);
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [SC_PROB_W-1:0] cfg_p_a;
   logic [SC_PROB_W-1:0] cfg_p_b;
   logic [SC_PROB_W-1:0] cfg_p_sel;
   logic [LEN_W-1:0]     cfg_len;
   logic                 res_valid;
   logic                 res_ready;
   logic [LEN_W:0]       res_count;
   logic                 dp_load;
   logic                 dp_run;
   logic                 dp_bit;
   logic [SC_PROB_W-1:0] dp_p_a;
   logic [SC_PROB_W-1:0] dp_p_b;
   logic [SC_PROB_W-1:0] dp_p_sel;

   // slave: the sequencer; master: host plus datapath environment
   modport slave (
      input  cfg_valid, cfg_p_a, cfg_p_b, cfg_p_sel, cfg_len, res_ready, dp_bit,
      output cfg_ready, res_valid, res_count, dp_load, dp_run, dp_p_a, dp_p_b, dp_p_sel
   );
   modport master (
      output cfg_valid, cfg_p_a, cfg_p_b, cfg_p_sel, cfg_len, res_ready, dp_bit,
      input  cfg_ready, res_valid, res_count, dp_load, dp_run, dp_p_a, dp_p_b, dp_p_sel
   );
endinterface

// File: rtl/sc_eval_sequencer_window_counter.sv
// Delays dp_run by the datapath latency to form the count window, and counts 1s inside it.
module sc_window_counter #(
   parameter int LEN_W  = 8,
   parameter int DP_LAT = 2
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic           i_clr,
   input  logic           i_run,
   input  logic           i_bit,
   output logic [LEN_W:0] o_count
);
   logic [DP_LAT-1:0] r_run_sr;
   logic [LEN_W:0]    r_count;
   logic              w_win;

   assign w_win   = r_run_sr[DP_LAT-1];
   assign o_count = r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst_n || i_clr) begin
         r_run_sr <= '0;
         r_count  <= '0;
      end else begin
         r_run_sr[0] <= i_run;
         for (int i = 1; i < DP_LAT; i++) r_run_sr[i] <= r_run_sr[i-1];
         if (w_win && i_bit) r_count <= r_count + 1'b1;
      end
   end
endmodule

// File: rtl/sc_eval_sequencer.sv
// Sequences one SC evaluation: accept job, reload seeds, run L cycles, flush, report count.
// Optional SC_SEED_ROTATE_EN: dp_load only on the first job after reset.
module sc_eval_sequencer
   import sc_pkg::*;
#(
   parameter int LEN_W  = SC_LEN_W,
   parameter int DP_LAT = SC_DP_LAT
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_abort,
   output logic                o_busy,
   sc_eval_sequencer_if.slave  bus
);
   localparam int FL_W = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;

   sc_state_e            r_state, w_next;
   logic [LEN_W-1:0]     r_len_cnt;
   logic [FL_W-1:0]      r_flush_cnt;
   logic [SC_PROB_W-1:0] r_p_a, r_p_b, r_p_sel;
   logic                 w_accept, w_abort, w_load_en;
   logic [LEN_W:0]       w_count;

   assign w_abort      = i_abort && (r_state != IDLE);
   assign o_busy       = (r_state != IDLE);
   assign bus.dp_p_a   = r_p_a;
   assign bus.dp_p_b   = r_p_b;
   assign bus.dp_p_sel = r_p_sel;
   assign bus.res_count = w_count;

`ifdef SC_SEED_ROTATE_EN
   // LFSRs keep running across jobs once seeded after reset
   logic r_seeded;
   assign w_load_en = ~r_seeded;
   always_ff @(posedge i_clk) begin
      if (i_rst_n)               r_seeded <= 1'b0;
      else if (r_state == LOAD)  r_seeded <= 1'b1;
   end
`else
   assign w_load_en = 1'b1;
`endif

   always_comb begin
      w_next        = r_state;
      w_accept      = 1'b0;
      bus.cfg_ready = 1'b0;
      bus.dp_load   = 1'b0;
      bus.dp_run    = 1'b0;
      bus.res_valid = 1'b0;
      case (r_state)
         IDLE: begin
            bus.cfg_ready = 1'b1;
            if (bus.cfg_valid) begin
               w_accept = 1'b1;
               w_next   = LOAD;
            end
         end
         LOAD: begin
            bus.dp_load = w_load_en;
            w_next      = RUN;
         end
         RUN: begin
            bus.dp_run = 1'b1;
            if (r_len_cnt == '0) w_next = FLUSH;
         end
         FLUSH: if (r_flush_cnt == '0) w_next = DONE;
         DONE: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      // abort wins over a same-cycle res_ready: the result is dropped
      if (w_abort) begin
         w_next        = IDLE;
         bus.dp_run    = 1'b0;
         bus.res_valid = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst_n) begin
         r_state     <= IDLE;
         r_len_cnt   <= '0;
         r_flush_cnt <= '0;
         r_p_a       <= '0;
         r_p_b       <= '0;
         r_p_sel     <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_len_cnt <= bus.cfg_len;
            r_p_a     <= bus.cfg_p_a;
            r_p_b     <= bus.cfg_p_b;
            r_p_sel   <= bus.cfg_p_sel;
         end else if (r_state == RUN && r_len_cnt != '0) begin
            r_len_cnt <= r_len_cnt - 1'b1;
         end
         if (r_state == RUN)
            r_flush_cnt <= FL_W'(DP_LAT - 1);
         else if (r_state == FLUSH && r_flush_cnt != '0)
            r_flush_cnt <= r_flush_cnt - 1'b1;
      end
   end

   sc_window_counter #(
      .LEN_W  (LEN_W),
      .DP_LAT (DP_LAT)
   ) u_win (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clr   (w_accept || w_abort),
      .i_run   (bus.dp_run),
      .i_bit   (bus.dp_bit),
      .o_count (w_count)
   );
endmodule

// File: tb/tb_sc_eval_sequencer.sv
// Bench for sc_eval_sequencer: cycle-index reference model, per-cycle compare, directed + random jobs.
module tb_sc_eval_sequencer;
   localparam int DP_LAT = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic abort = 1'b0;
   logic busy;
   int   mode = 1;     // dp_bit source: 0 random, 1 constant 1, 2 window-edge pattern, 3 LFSR stub
   logic rnd_bit = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   sc_eval_sequencer_if #(.LEN_W(8)) bus ();

   sc_eval_sequencer dut (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_abort (abort),
      .o_busy  (busy),
      .bus     (bus.slave)
   );

   // reference model: position k within a job counted from the accept cycle
   bit       m_started = 0, m_busy = 0, m_seeded = 0;
   int       m_k = 0, m_L = 1, m_sum = 0, m_hold = 0;
   logic [3:0] m_pa = 0, m_pb = 0, m_ps = 0;

   // small SNG/MUX datapath stub, two register stages
   logic [3:0] s_lfsr = 4'h1;
   logic s_a = 0, s_b = 0, s_sel = 0, s_mux = 0;
   always @(posedge clk) begin
      if (bus.dp_load)     s_lfsr <= 4'h1;
      else if (bus.dp_run) s_lfsr <= {s_lfsr[2:0], s_lfsr[3] ^ s_lfsr[2]};
      s_a   <= (s_lfsr < bus.dp_p_a);
      s_b   <= (s_lfsr < bus.dp_p_b);
      s_sel <= (s_lfsr < bus.dp_p_sel);
      s_mux <= s_sel ? s_a : s_b;
   end

   assign bus.dp_bit = (mode == 3) ? s_mux :
                       (mode == 2) ? (m_busy && (m_k == 2 || m_k == 3 || m_k == m_L + 2 + DP_LAT ||
                                                 m_k == m_L + 3 + DP_LAT)) :
                       (mode == 1) ? 1'b1 : rnd_bit;

   always @(posedge clk) begin
      if (rst) begin
         m_started <= 1; m_busy <= 0; m_seeded <= 0; m_hold <= 0;
         m_pa <= 0; m_pb <= 0; m_ps <= 0;
      end else if (!m_busy) begin
         if (bus.cfg_valid) begin
            m_busy <= 1; m_k <= 1; m_L <= int'(bus.cfg_len) + 1; m_sum <= 0;
            m_pa <= bus.cfg_p_a; m_pb <= bus.cfg_p_b; m_ps <= bus.cfg_p_sel;
         end
      end else begin
         if (m_k == 1) m_seeded <= 1;
         if (abort) begin
            m_busy <= 0; m_hold <= 0;
         end else if (m_k >= m_L + 2 + DP_LAT && bus.res_ready) begin
            m_busy <= 0; m_hold <= m_sum;
         end else begin
            m_k <= m_k + 1;
            if (m_k >= 2 + DP_LAT && m_k <= m_L + 1 + DP_LAT && bus.dp_bit) m_sum <= m_sum + 1;
         end
      end
   end

   always @(negedge clk) begin
      bit e_load, e_run, e_rv, ck_cnt, bad, load_ok;
      int e_cnt;
      if (m_started) begin
`ifdef SC_SEED_ROTATE_EN
         load_ok = !m_seeded;
`else
         load_ok = 1'b1;
`endif
         e_load = m_busy && m_k == 1 && load_ok;
         e_run  = m_busy && m_k >= 2 && m_k <= m_L + 1 && !abort;
         e_rv   = m_busy && m_k >= m_L + 2 + DP_LAT && !abort;
         ck_cnt = !m_busy || (m_k >= m_L + 2 + DP_LAT);
         e_cnt  = m_busy ? m_sum : m_hold;
         bad = (bus.cfg_ready !== !m_busy) || (busy !== m_busy) || (bus.dp_load !== e_load) ||
               (bus.dp_run !== e_run) || (bus.res_valid !== e_rv) ||
               (ck_cnt && (int'(bus.res_count) != e_cnt || $isunknown(bus.res_count))) ||
               (bus.dp_p_a !== m_pa) || (bus.dp_p_b !== m_pb) || (bus.dp_p_sel !== m_ps);
         n_cmp++;
         if (bad) begin
            n_err++;
            $display("FAIL model t=%0t: rdy %b/%b busy %b/%b load %b/%b run %b/%b rv %b/%b cnt %0d/%0d pa %h/%h pb %h/%h ps %h/%h (got/exp)",
                     $time, bus.cfg_ready, !m_busy, busy, m_busy, bus.dp_load, e_load, bus.dp_run, e_run,
                     bus.res_valid, e_rv, bus.res_count, ck_cnt ? e_cnt : -1, bus.dp_p_a, m_pa,
                     bus.dp_p_b, m_pb, bus.dp_p_sel, m_ps);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic start_job(input logic [3:0] pa, pb, ps, input logic [7:0] len);
      bit ok = 0;
      bus.cfg_p_a = pa; bus.cfg_p_b = pb; bus.cfg_p_sel = ps; bus.cfg_len = len;
      bus.cfg_valid = 1'b1;
      for (int i = 0; i < 10 && !ok; i++) begin
         @(negedge clk);
         if (bus.cfg_ready) ok = 1;
         @(posedge clk); #1;
      end
      bus.cfg_valid = 1'b0;
      if (!ok) chk("accept_timeout", 0, 1);
   endtask

   task automatic do_job(input logic [3:0] pa, pb, ps, input logic [7:0] len, input int hold,
                         output int cnt, output int lat, output int runs);
      bit ok = 0;
      int bad = 0;
      start_job(pa, pb, ps, len);
      lat = 0; runs = 0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         @(negedge clk);
         lat++;
         if (bus.dp_run) runs++;
         if (bus.res_valid) ok = 1;
      end
      if (!ok) chk("res_timeout", 0, 1);
      cnt = int'(bus.res_count);
      @(posedge clk); #1;
      if (hold > 0) begin
         bus.cfg_valid = 1'b1;
         repeat (hold) begin
            @(negedge clk);
            if (int'(bus.res_count) != cnt || !bus.res_valid || bus.cfg_ready) bad++;
            @(posedge clk); #1;
         end
         bus.cfg_valid = 1'b0;
         chk("done_hold_unstable_cycles", bad, 0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      bus.res_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, lat, runs;
      bus.cfg_valid = 0; bus.cfg_len = 0; bus.cfg_p_a = 0; bus.cfg_p_b = 0; bus.cfg_p_sel = 0;
      bus.res_ready = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_cfg_ready", bus.cfg_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_res_count", bus.res_count, 0);
      chk("rst_dp_run", bus.dp_run, 0);
      @(posedge clk); #1;

      mode = 1;
      do_job(4'h3, 4'h5, 4'h7, 8'd255, 0, cnt, lat, runs);
      chk("len256_count", cnt, 256);
      chk("len256_run_cycles", runs, 256);
      chk("pa_latched", bus.dp_p_a, 3);

      do_job(4'h1, 4'h2, 4'h3, 8'd0, 0, cnt, lat, runs);
      chk("len1_count", cnt, 1);
      chk("len1_latency", lat, 5);

      mode = 2;
      do_job(4'h0, 4'h0, 4'h0, 8'd15, 0, cnt, lat, runs);
      chk("window_edge_count", cnt, 0);

      mode = 1;
      start_job(4'h9, 4'h9, 4'h9, 8'd63);
      repeat (10) begin @(posedge clk); #1; end
      abort = 1'b1;
      @(negedge clk);
      chk("abort_dp_run", bus.dp_run, 0);
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_idle_busy", busy, 0);
      chk("abort_count_cleared", bus.res_count, 0);
      @(posedge clk); #1;
      do_job(4'h2, 4'h2, 4'h2, 8'd7, 0, cnt, lat, runs);
      chk("after_abort_count", cnt, 8);

      do_job(4'h4, 4'h4, 4'h4, 8'd11, 20, cnt, lat, runs);
      chk("hold_count", cnt, 12);

      start_job(4'h6, 4'h6, 4'h6, 8'd20);
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midjob_rst_busy", busy, 0);
      chk("midjob_rst_pa", bus.dp_p_a, 0);
      @(posedge clk); #1;

      mode = 3;
      do_job(4'h0, 4'h0, 4'h8, 8'd255, 0, cnt, lat, runs);
      chk("sng_zero_prob", cnt, 0);
      do_job(4'hf, 4'hf, 4'h8, 8'd255, 0, cnt, lat, runs);
`ifndef SC_SEED_ROTATE_EN
      chk("sng_full_prob", cnt, 239);
`endif

      mode = 0;
      for (int c = 0; c < 4000; c++) begin
         @(posedge clk); #1;
         bus.cfg_valid = ($urandom_range(0, 3) == 0);
         bus.cfg_len   = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
         bus.cfg_p_a   = 4'($urandom);
         bus.cfg_p_b   = 4'($urandom);
         bus.cfg_p_sel = 4'($urandom);
         bus.res_ready = ($urandom_range(0, 2) == 0);
         abort         = ($urandom_range(0, 50) == 0);
         rnd_bit       = 1'($urandom);
         rst           = ($urandom_range(0, 700) == 0);
      end
      @(posedge clk); #1;
      bus.cfg_valid = 0; abort = 0; rst = 0; bus.res_ready = 1;
      repeat (300) @(posedge clk);
      #1;
      @(negedge clk);
      chk("drain_idle", busy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
